// File: rtl/ex_muldiv_unit_if.sv
// rtl/ex_muldiv_unit_if.sv - EX-stage mul/div request and result bundle
interface ex_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] rs_data_i;
  logic [WIDTH-1:0] rt_data_i;
  logic             flush_i;
  logic             stall_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;

  modport master (
    output start_i, op_i, rs_data_i, rt_data_i, flush_i,
    input  stall_o, busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_i, rs_data_i, rt_data_i, flush_i,
    output stall_o, busy_o, done_o, result_o
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative unsigned multiply/divide unit for the EX stage
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  ex_muldiv_unit_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_result;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_shift;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_diff;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;

  // {r_hi, r_lo} is the product (shifting right) or {rem, quot} (shifting left)
  assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
  assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
  assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_opnd;

  always_comb begin
    w_hi_nxt = w_mul_sum[WIDTH:1];
    w_lo_nxt = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    if (r_op[1]) begin
      w_hi_nxt = w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
      w_lo_nxt = {r_lo[WIDTH-2:0], w_div_ge};
    end
  end

  assign w_accept = (r_state == S_IDLE) && bus.start_i && !bus.flush_i;
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_op    <= bus.op_i;
            r_opnd  <= bus.rt_data_i;
            r_lo    <= bus.rs_data_i;
            r_hi    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (bus.flush_i) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
              // High half serves MULHU and REMU, low half MUL and DIVU
              r_result <= r_op[0] ? w_hi_nxt : w_lo_nxt;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.stall_o  = w_accept || (r_state == S_BUSY);
  assign bus.busy_o   = r_busy;
  assign bus.done_o   = r_done;
  assign bus.result_o = r_result;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - scoreboard bench for ex_muldiv_unit
module tb_ex_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [W-1:0] sb_q[$];
  logic [W-1:0] last_exp = '0;

  ex_muldiv_unit_if #(.WIDTH(W)) bus ();
  ex_muldiv_unit #(.WIDTH(W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (op)
      2'd0:    return p[W-1:0];
      2'd1:    return p[2*W-1:W];
      2'd2:    return (b == '0) ? {W{1'b1}} : a / b;
      default: return (b == '0) ? a : a % b;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.done_o) begin
      check("done_busy_exclusive", W'(bus.busy_o), '0);
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got done_o=1 with result 0x%08h, required no done", bus.result_o);
      end else begin
        check("result", bus.result_o, sb_q.pop_front());
      end
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit hold, input bit chg, input string name);
    int stall_cnt;
    bit seen;
    logic [W-1:0] exp;
    @(posedge clk); #1;
    check({name, "_idle_busy"}, W'(bus.busy_o), '0);
    check({name, "_result_held"}, bus.result_o, last_exp);
    bus.start_i   = 1'b1;
    bus.op_i      = op;
    bus.rs_data_i = a;
    bus.rt_data_i = b;
    exp = model(op, a, b);
    sb_q.push_back(exp);
    stall_cnt = 0;
    seen = 1'b0;
    for (int c = 0; c < W + 10 && !seen; c++) begin
      @(negedge clk);
      if (bus.done_o) begin
        seen = 1'b1;
        check({name, "_stall_in_done"}, W'(bus.stall_o), '0);
      end else begin
        if (bus.stall_o) stall_cnt++;
        @(posedge clk); #1;
        if (!hold) bus.start_i = 1'b0;
        if (chg) begin
          bus.rs_data_i = $urandom;
          bus.rt_data_i = $urandom;
        end
      end
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: got no done_o within %0d cycles, required done_o", name, W + 10);
    end
    check({name, "_stall_cycles"}, W'(stall_cnt), W'(W + 1));
    last_exp = exp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] op;
    logic [W-1:0] a, b;
    bus.start_i = 1'b0; bus.op_i = '0; bus.rs_data_i = '0; bus.rt_data_i = '0; bus.flush_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", W'(bus.busy_o), '0);
    check("reset_done", W'(bus.done_o), '0);
    check("reset_stall", W'(bus.stall_o), '0);
    check("reset_result", bus.result_o, '0);
    rst = 1'b0;

    run_op(2'd0, 32'd7, 32'd6, 0, 0, "mul_7x6");
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, "mulhu_max");
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, "mul_max");
    run_op(2'd2, 32'd100, 32'd7, 0, 0, "divu_100_7");
    run_op(2'd3, 32'd100, 32'd7, 0, 0, "remu_100_7");
    run_op(2'd2, 32'h1234_5678, 32'd0, 0, 0, "divu_by_zero");
    run_op(2'd3, 32'h1234_5678, 32'd0, 0, 0, "remu_by_zero");

    // Flush at BUSY cycle 10
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.op_i = 2'd0; bus.rs_data_i = $urandom; bus.rt_data_i = $urandom;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("flush_pre_busy", W'(bus.busy_o), W'(1));
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    check("flush_busy", W'(bus.busy_o), '0);
    check("flush_stall", W'(bus.stall_o), '0);
    check("flush_done", W'(bus.done_o), '0);
    check("flush_result_held", bus.result_o, last_exp);
    repeat (W + 5) @(posedge clk);

    // Reset at BUSY cycle 5
    #1;
    bus.start_i = 1'b1; bus.op_i = 2'd2; bus.rs_data_i = $urandom; bus.rt_data_i = 32'd3;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midop_reset_busy", W'(bus.busy_o), '0);
    check("midop_reset_done", W'(bus.done_o), '0);
    check("midop_reset_stall", W'(bus.stall_o), '0);
    check("midop_reset_result", bus.result_o, '0);
    rst = 1'b0;
    last_exp = '0;
    repeat (W + 5) @(posedge clk);

    run_op(2'd0, 32'd12345, 32'd678, 1, 1, "mul_hold_start");
    run_op(2'd2, 32'hDEAD_BEEF, 32'd1000, 1, 1, "divu_hold_start");

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 7) == 0) b = '0;
      else if ($urandom_range(0, 1) == 1) b = $urandom;
      else b = W'($urandom_range(1, 255));
      run_op(op, a, b, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), "random");
    end

    @(posedge clk); #1;
    bus.start_i = 1'b0;
    check("final_busy", W'(bus.busy_o), '0);
    check("final_result_held", bus.result_o, last_exp);
    @(negedge clk);
    check("final_done", W'(bus.done_o), '0);
    check("scoreboard_empty", W'(sb_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Iterative multiply/divide unit in the EX stage. It consumes the operands and control latched by the ID/EX pipeline register and asserts a stall back to the PC, IF/ID and ID/EX registers while it computes. Results are produced over WIDTH cycles with a one-cycle done strobe, and are muxed into the EX result path. Only unsigned operations are supported; the main ALU handles everything else.

Parameters:
WIDTH, 32, operand and result width; BUSY phase lasts exactly WIDTH cycles.

Ports:
clk_i  input  1  clock; all state updates on rising edge.
rst_i  input  1  synchronous, active-high reset.
start_i  input  1  ID/EX holds a mul/div instruction (decoded valid).
op_i  input  2  00 MUL (low half), 01 MULHU (high half), 10 DIVU (quotient), 11 REMU (remainder).
rs_data_i  input  WIDTH  operand A / dividend (forwarded RS data).
rt_data_i  input  WIDTH  operand B / divisor (forwarded RT data).
flush_i  input  1  abort the in-flight operation (branch flush).
stall_o  output  1  freeze PC, IF/ID and ID/EX.
busy_o  output  1  state is BUSY.
done_o  output  1  one-cycle strobe; result_o valid.
result_o  output  WIDTH  selected result; held until the next accepted start.

Behaviour:
- Reset (rst_i=1 at an edge): state=IDLE, counter=0, result_o=0, done_o=0, busy_o=0. Reset has priority over all inputs, including mid-operation; no done_o follows.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If start_i=1 and flush_i=0: latch op_i and both operands, clear the accumulator/remainder, counter=0, go to BUSY.
  - If flush_i=1, start_i is ignored.
- BUSY, one iteration per cycle, counter increments:
  - MUL/MULHU: radix-2 shift-add into a 2*WIDTH product register.
  - DIVU/REMU: restoring divide. Shift {rem,quot} left 1. If rem >= divisor, subtract and set quot LSB.
  - When counter==WIDTH-1, go to DONE next edge. BUSY lasts exactly WIDTH cycles.
- BUSY with flush_i=1: go to IDLE next edge; no done_o; result_o unchanged.
- DONE, one cycle:
  - done_o=1. result_o = product[WIDTH-1:0] (MUL), product[2W-1:W] (MULHU), quotient (DIVU) or remainder (REMU).
  - result_o is registered on the BUSY->DONE edge.
  - Always return to IDLE. start_i is ignored in DONE because ID/EX still holds the same instruction. flush_i in DONE has no effect (result already delivered).
- stall_o is combinational: (IDLE & start_i & ~flush_i) | BUSY. It is low in DONE so the pipeline advances on the DONE edge.
- Latency: start sampled at edge E0 → done_o high during cycle E0+WIDTH+1. Total stall = WIDTH+1 cycles including the acceptance cycle. Back-to-back ops: the next start is accepted in the IDLE cycle after DONE.
- Divide by zero (divisor latched as 0): quotient = all ones, remainder = dividend. Timing is the normal WIDTH cycles.
- Operands are latched at acceptance. Changes on rs/rt_data_i during BUSY have no effect.
- busy_o = (state==BUSY). done_o and busy_o are never high together.

Test Plan:
1. Reset, then start MUL, rs=7, rt=6 → stall_o high for 33 cycles, done_o pulse at cycle 33 with result_o=42. stall_o low in the DONE cycle.
2. MULHU with rs=rt=0xFFFFFFFF → result_o=0xFFFFFFFE. Repeat with MUL → result_o=0x00000001.
3. DIVU rs=100, rt=7 → result_o=14. Then REMU with the same operands, started the cycle after return to IDLE → result_o=2.
4. DIVU rs=0x12345678, rt=0 → result_o=0xFFFFFFFF. REMU with the same operands → result_o=0x12345678. Both take normal latency.
5. Start MUL, pulse flush_i at BUSY cycle 10 → IDLE next edge, no done_o, stall_o drops, result_o keeps its previous value. Then rst_i asserted at BUSY cycle 5 of a new op → all outputs 0, state IDLE.
6. Hold start_i=1 through DONE with rs/rt changing during BUSY → exactly one done_o, result computed from operands latched at acceptance, no re-trigger in DONE.
